// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
// Byte FIFO plus launch sequencer between the CPU's UART write path and a
// UART transmitter. The CPU pushes bytes at bus speed; the sequencer pops
// them one at a time and hands each to the transmitter with a one-cycle
// data-valid pulse, then waits for the transmitter's active/done handshake.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   wr_en      CPU write strobe (one byte per cycle)
//   wr_data    byte to queue
//   clr_ovf    clears the sticky overflow flag
//   full       count == DEPTH
//   empty      count == 0
//   count      bytes queued (the byte in flight is not counted)
//   overflow   sticky: a write was dropped because the FIFO was full
//   busy       sequencer not idle, or FIFO not empty
//   tx_byte    byte presented to the transmitter (held until next launch)
//   tx_dv      one-cycle data-valid pulse to the transmitter
//   tx_active  transmitter busy
//   tx_done    transmitter done (high for two cycles after the stop bit)
module uart_tx_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic [7:0]        tx_byte,
  output logic              tx_dv,
  input  logic              tx_active,
  input  logic              tx_done
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ACT  = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state;
  state_t            state_nx;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;
  logic              drop;

  // Status decodes come only from registered count/state.
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign busy  = (state != S_IDLE) || !empty;

  // Fullness is judged on the registered count, so a write arriving while
  // full is dropped even if a pop frees a slot in the same cycle.
  assign push = wr_en && !full;
  assign drop = wr_en && full;

  // Launch guard also requires tx_done low: this skips the transmitter's
  // second done cycle and keeps DV away from a transmitter that is still
  // finishing a byte after a reset of this block.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !tx_active && !tx_done) begin
          pop      = 1'b1;
          state_nx = S_WAIT_ACT;
        end
      end
      S_WAIT_ACT: begin
        if (tx_active) state_nx = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_dv    <= 1'b0;
      tx_byte  <= 8'h00;
    end else begin
      tx_dv <= pop;
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        tx_byte <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      // A dropped write wins over a simultaneous clear.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Storage carries no reset; only written slots are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
module tb_uart_tx_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CPB    = 4;
  // tx_done visible in cycles a and a+1, launch decided in a+2,
  // registered DV visible in a+3.
  localparam int DV_GAP = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clr_ovf;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              busy;
  logic [7:0]        tx_byte;
  logic              tx_dv;
  logic              tx_active;
  logic              tx_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  logic hold_busy = 1'b0;
  logic gap_en    = 1'b0;

  always #5 clk = ~clk;

  uart_tx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .clr_ovf(clr_ovf), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .busy(busy), .tx_byte(tx_byte), .tx_dv(tx_dv),
    .tx_active(tx_active), .tx_done(tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: no reset, 8N1 at CPB clocks per bit, done for two cycles.
  typedef enum logic [2:0] {M_IDLE, M_START, M_DATA, M_STOP, M_CLEAN} mstate_t;
  mstate_t    m_state  = M_IDLE;
  logic       m_active = 1'b0;
  logic       m_done   = 1'b0;
  logic       ser      = 1'b1;
  logic [7:0] m_shreg  = 8'h00;
  int         m_cnt    = 0;
  int         m_bit    = 0;

  assign tx_active = m_active | hold_busy;
  assign tx_done   = m_done;

  always @(posedge clk) begin
    case (m_state)
      M_IDLE: begin
        ser    <= 1'b1;
        m_done <= 1'b0;
        if (tx_dv) begin
          m_shreg  <= tx_byte;
          m_active <= 1'b1;
          m_cnt    <= 0;
          m_state  <= M_START;
        end
      end
      M_START: begin
        ser <= 1'b0;
        if (m_cnt == CPB-1) begin m_cnt <= 0; m_bit <= 0; m_state <= M_DATA; end
        else m_cnt <= m_cnt + 1;
      end
      M_DATA: begin
        ser <= m_shreg[m_bit];
        if (m_cnt == CPB-1) begin
          m_cnt <= 0;
          if (m_bit == 7) m_state <= M_STOP;
          else m_bit <= m_bit + 1;
        end else m_cnt <= m_cnt + 1;
      end
      M_STOP: begin
        ser <= 1'b1;
        if (m_cnt == CPB-1) begin
          m_cnt    <= 0;
          m_active <= 1'b0;
          m_done   <= 1'b1;
          m_state  <= M_CLEAN;
        end else m_cnt <= m_cnt + 1;
      end
      default: m_state <= M_IDLE;
    endcase
  end

  // Serial receiver: decodes the line and pops the scoreboard.
  logic [7:0] rx_val;
  initial begin
    forever begin
      @(negedge ser);
      repeat (CPB/2) @(posedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(posedge clk);
        rx_val[b] = ser;
      end
      repeat (CPB) @(posedge clk);
      chk("rx_stop", 32'(ser), 32'd1);
      chk("rx_expected_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("rx_byte", 32'(rx_val), 32'(exp_q.pop_front()));
    end
  end

  // DV monitor: pulse width, transmitter state, spacing after done.
  int   cyc = 0;
  int   dv_total = 0;
  int   done_rise = 0;
  logic prev_done = 1'b0;
  logic prev_dv = 1'b0;
  logic gap_armed = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!gap_en) gap_armed = 1'b0;
    if (tx_done && !prev_done) done_rise = cyc;
    if (tx_dv === 1'b1) begin
      dv_total++;
      chk("dv_width", 32'(prev_dv), 32'd0);
      chk("dv_model_idle", 32'(m_state == M_IDLE && !m_done), 32'd1);
      if (gap_en && gap_armed) chk("dv_gap", 32'(cyc - done_rise), 32'(DV_GAP));
      if (gap_en) gap_armed = 1'b1;
    end
    prev_done = tx_done;
    prev_dv   = (tx_dv === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (n < max && (exp_q.size() != 0 || busy || m_state != M_IDLE || m_done)) begin
      tick();
      n++;
    end
    chk("drain_in_time", 32'(n < max), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv_base;
    int n;
    int idx;
    logic dv_early;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
    tick(); tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_dv", 32'(tx_dv), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    reset = 1'b0;

    // Idle after reset
    repeat (20) tick();
    chk("idle_dv_count", 32'(dv_total), 32'd0);
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_full", 32'(full), 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Three bytes back to back
    dv_base = dv_total;
    gap_en  = 1'b1;
    tick();
    exp_q.push_back(8'h55); wr(8'h55);
    exp_q.push_back(8'hA3); wr(8'hA3);
    exp_q.push_back(8'h0F); wr(8'h0F);
    wait_drain(600);
    gap_en = 1'b0;
    chk("b2b_dv_pulses", 32'(dv_total - dv_base), 32'd3);
    chk("b2b_count", 32'(count), 32'd0);

    // Fill while transmitter held busy, then overflow
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      wr(8'(i));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_no_ovf", 32'(overflow), 32'd0);
    wr(8'h10);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    hold_busy = 1'b0;
    wait_drain(2000);
    chk("fill_drained_count", 32'(count), 32'd0);

    // Write while full in the same cycle as a pop
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h80 + i));
      wr(8'(8'h80 + i));
    end
    chk("pop_full_pre", 32'(full), 32'd1);
    hold_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    chk("pop_full_count", 32'(count), 32'd15);
    chk("pop_full_ovf", 32'(overflow), 32'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    wait_drain(2000);

    // Stream 40 bytes gated by full
    idx = 0; n = 0;
    while (idx < 40 && n < 5000) begin
      if (!full) begin
        wr_en = 1'b1; wr_data = 8'(idx * 7 + 3);
        exp_q.push_back(8'(idx * 7 + 3));
        idx++;
      end else wr_en = 1'b0;
      tick();
      n++;
    end
    wr_en = 1'b0;
    chk("stream_all_written", 32'(idx), 32'd40);
    chk("stream_no_ovf", 32'(overflow), 32'd0);
    wait_drain(4000);
    chk("stream_count", 32'(count), 32'd0);

    // Reset while the second of four bytes is on the line
    dv_base = dv_total;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'hC1 + i));
      wr(8'(8'hC1 + i));
    end
    n = 0;
    while (dv_total < dv_base + 2 && n < 500) begin tick(); n++; end
    chk("second_dv_seen", 32'(dv_total - dv_base), 32'd2);
    repeat (10) tick();
    reset = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_tx_dv", 32'(tx_dv), 32'd0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    tick(); tick();
    reset = 1'b0;
    exp_q.push_back(8'h5A);
    wr(8'h5A);
    dv_early = 1'b0; n = 0;
    while ((m_active || m_done) && n < 200) begin
      dv_early = dv_early | tx_dv;
      tick();
      n++;
    end
    chk("quiet_in_time", 32'(n < 200), 32'd1);
    chk("no_dv_before_quiet", 32'(dv_early), 32'd0);
    wait_drain(600);
    chk("after_rst_count", 32'(count), 32'd0);
    chk("after_rst_ovf", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
